btb_tagged: RTL

Parametrised, tagged, direct-mapped branch target buffer with per-entry 2-bit saturating direction counters. It sits between the fetch stage and the branch-resolution stage of the MIPS pipeline. Fetch looks up the current PC and receives hit, taken prediction and target one cycle later. The resolution stage reports each executed branch's outcome, and the block allocates or trains the matching entry internally.

---
 rtl/btb_tagged.sv | 84 ++++++++
 1 files changed

// File: rtl/btb_tagged.sv
// Tagged direct-mapped branch target buffer with 2-bit saturating direction counters.
// The lookup index/tag is registered and the outputs read the arrays directly, so updates are visible write-first.
module btb_tagged #(
  parameter int ADDR_W  = 32,
  parameter int INDEX_W = 6
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              FetchEn,
  input  logic [ADDR_W-1:0] FetchPC,
  output logic              Hit,
  output logic              PredTaken,
  output logic [ADDR_W-1:0] PredTarget,
  input  logic              UpdValid,
  input  logic [ADDR_W-1:0] UpdPC,
  input  logic              UpdTaken,
  input  logic [ADDR_W-1:0] UpdTarget,
  input  logic              Flush
);
  localparam int TAG_W = ADDR_W - 2 - INDEX_W;
  localparam int DEPTH = 1 << INDEX_W;

  logic [DEPTH-1:0]        r_valid;
  logic [DEPTH-1:0][1:0]   r_ctr;
  logic [TAG_W-1:0]        r_tag [DEPTH];
  logic [ADDR_W-1:0]       r_tgt [DEPTH];
  logic [INDEX_W-1:0]      r_lidx;
  logic [TAG_W-1:0]        r_ltag;

  logic [INDEX_W-1:0]      w_uidx;
  logic [TAG_W-1:0]        w_utag;
  logic                    w_umatch;
  logic                    w_wr;
  logic                    w_unused;

  assign w_uidx   = UpdPC[INDEX_W+1:2];
  assign w_utag   = UpdPC[ADDR_W-1:INDEX_W+2];
  assign w_umatch = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);
  // Both a taken match and a taken miss write tag/target; on a match the tag is unchanged.
  assign w_wr     = Rst_n && UpdValid && UpdTaken && !Flush;
  assign w_unused = ^{FetchPC[1:0], UpdPC[1:0]};

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_valid <= '0;
      r_ctr   <= {DEPTH{2'b01}};
      r_lidx  <= '0;
      r_ltag  <= '0;
    end else begin
      if (FetchEn) begin
        r_lidx <= FetchPC[INDEX_W+1:2];
        r_ltag <= FetchPC[ADDR_W-1:INDEX_W+2];
      end
      // Flush wins: a same-cycle update is dropped entirely.
      if (Flush) begin
        r_valid <= '0;
      end else if (UpdValid) begin
        if (w_umatch) begin
          if (UpdTaken)
            r_ctr[w_uidx] <= (r_ctr[w_uidx] == 2'b11) ? 2'b11 : r_ctr[w_uidx] + 2'd1;
          else
            r_ctr[w_uidx] <= (r_ctr[w_uidx] == 2'b00) ? 2'b00 : r_ctr[w_uidx] - 2'd1;
        end else if (UpdTaken) begin
          r_valid[w_uidx] <= 1'b1;
          r_ctr[w_uidx]   <= 2'b10;
        end
      end
    end
  end

  // Payload arrays carry no reset; valid gates every use of them.
  always_ff @(posedge Clk) begin
    if (w_wr) begin
      r_tag[w_uidx] <= w_utag;
      r_tgt[w_uidx] <= UpdTarget;
    end
  end

  always_comb begin
    Hit        = r_valid[r_lidx] && (r_tag[r_lidx] == r_ltag);
    PredTaken  = Hit && r_ctr[r_lidx][1];
    PredTarget = Hit ? r_tgt[r_lidx] : '0;
  end
endmodule
